// File: rtl/spu_fwd_network.sv
// Result-forwarding network for the dual-issue SPU: one DEPTH-stage result pipe per
// issue slot, register-file writeback from the last stage, and operand bypass per read port.

module spu_fwd_pipe #(
  parameter int QUADWORD       = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int UNIT_ID_SIZE   = 3,
  parameter int DEPTH          = 8,
  parameter int STG_W          = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 iss_v,
  input  logic                                 iss_wr,
  input  logic [REG_ADDR_WIDTH-1:0]            iss_addr,
  input  logic [UNIT_ID_SIZE-1:0]              iss_uid,
  input  logic                                 res_v,
  input  logic [STG_W-1:0]                     res_stg,
  input  logic [QUADWORD-1:0]                  res_data,
  output logic [DEPTH:1]                       st_vld,
  output logic [DEPTH:1]                       st_wr,
  output logic [DEPTH:1]                       st_rdy,
  output logic [DEPTH:1][REG_ADDR_WIDTH-1:0]   st_addr,
  output logic [DEPTH:1][QUADWORD-1:0]         st_data
);
  typedef struct packed {
    logic                      vld;
    logic                      wr;
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [UNIT_ID_SIZE-1:0]   uid;
    logic                      rdy;
    logic [QUADWORD-1:0]       data;
  } ent_t;

  ent_t             iss_ent;
  ent_t [DEPTH:1]   stg_q, stg_d, src;

  assign iss_ent = '{vld: iss_v, wr: iss_wr, addr: iss_addr, uid: iss_uid, rdy: 1'b0, data: '0};
  assign src     = {stg_q[DEPTH-1:1], iss_ent};

  // A result lands on the entry arriving at its stage, so it is applied to next state.
  always_comb begin
    stg_d = src;
    for (int k = 1; k <= DEPTH; k++) begin
      if (flush) stg_d[k].vld = 1'b0;
      if (res_v && res_stg == STG_W'(k) && stg_d[k].vld && stg_d[k].wr) begin
        stg_d[k].rdy  = 1'b1;
        stg_d[k].data = res_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) stg_q <= '0;
    else       stg_q <= stg_d;

  always_comb begin
    st_vld  = '0;
    st_wr   = '0;
    st_rdy  = '0;
    st_addr = '0;
    st_data = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      st_vld[k]  = stg_q[k].vld;
      st_wr[k]   = stg_q[k].wr;
      st_rdy[k]  = stg_q[k].rdy;
      st_addr[k] = stg_q[k].addr;
      st_data[k] = stg_q[k].data;
    end
  end
endmodule

module spu_fwd_port #(
  parameter int QUADWORD       = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int DEPTH          = 8
) (
  input  logic [REG_ADDR_WIDTH-1:0]          rd_addr,
  input  logic [QUADWORD-1:0]                rf_data,
  input  logic [DEPTH:1]                     vld_e,
  input  logic [DEPTH:1]                     wr_e,
  input  logic [DEPTH:1]                     rdy_e,
  input  logic [DEPTH:1][REG_ADDR_WIDTH-1:0] addr_e,
  input  logic [DEPTH:1][QUADWORD-1:0]       data_e,
  input  logic [DEPTH:1]                     vld_o,
  input  logic [DEPTH:1]                     wr_o,
  input  logic [DEPTH:1]                     rdy_o,
  input  logic [DEPTH:1][REG_ADDR_WIDTH-1:0] addr_o,
  input  logic [DEPTH:1][QUADWORD-1:0]       data_o,
  output logic [QUADWORD-1:0]                op_data,
  output logic                               op_hazard
);
  logic                hit, hit_rdy;
  logic [QUADWORD-1:0] hit_data;

  // Scan oldest to youngest, even before odd: the last match is the youngest producer.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_e[k] && wr_e[k] && addr_e[k] == rd_addr) begin
        hit = 1'b1; hit_rdy = rdy_e[k]; hit_data = data_e[k];
      end
      if (vld_o[k] && wr_o[k] && addr_o[k] == rd_addr) begin
        hit = 1'b1; hit_rdy = rdy_o[k]; hit_data = data_o[k];
      end
    end
  end

  assign op_hazard = hit & ~hit_rdy;
  assign op_data   = (hit && hit_rdy) ? hit_data : rf_data;
endmodule

module spu_fwd_network #(
  parameter int QUADWORD       = 128,
  parameter int REG_ADDR_WIDTH = 7,
  parameter int UNIT_ID_SIZE   = 3,
  parameter int DEPTH          = 8,
  parameter int NUM_RD         = 5,
  parameter int STG_W          = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               iss_v_e,
  input  logic                               iss_v_o,
  input  logic                               iss_wr_e,
  input  logic                               iss_wr_o,
  input  logic [REG_ADDR_WIDTH-1:0]          iss_addr_e,
  input  logic [REG_ADDR_WIDTH-1:0]          iss_addr_o,
  input  logic [UNIT_ID_SIZE-1:0]            iss_uid_e,
  input  logic [UNIT_ID_SIZE-1:0]            iss_uid_o,
  input  logic                               res_v_e,
  input  logic                               res_v_o,
  input  logic [STG_W-1:0]                   res_stg_e,
  input  logic [STG_W-1:0]                   res_stg_o,
  input  logic [QUADWORD-1:0]                res_data_e,
  input  logic [QUADWORD-1:0]                res_data_o,
  output logic                               wb_en_e,
  output logic                               wb_en_o,
  output logic [REG_ADDR_WIDTH-1:0]          wb_addr_e,
  output logic [REG_ADDR_WIDTH-1:0]          wb_addr_o,
  output logic [QUADWORD-1:0]                wb_data_e,
  output logic [QUADWORD-1:0]                wb_data_o,
  input  logic [NUM_RD*REG_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [NUM_RD*QUADWORD-1:0]         rf_data,
  output logic [NUM_RD*QUADWORD-1:0]         op_data,
  output logic [NUM_RD-1:0]                  op_hazard,
  output logic                               err_unready,
  output logic [15:0]                        hazard_cnt
);
  localparam int AW = REG_ADDR_WIDTH;
  localparam int QW = QUADWORD;

  logic [DEPTH:1]         vld_e, wr_e, rdy_e, vld_o, wr_o, rdy_o;
  logic [DEPTH:1][AW-1:0] addr_e, addr_o;
  logic [DEPTH:1][QW-1:0] data_e, data_o;

  spu_fwd_pipe #(.QUADWORD(QW), .REG_ADDR_WIDTH(AW), .UNIT_ID_SIZE(UNIT_ID_SIZE),
                 .DEPTH(DEPTH), .STG_W(STG_W)) u_pipe_e (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_v(iss_v_e), .iss_wr(iss_wr_e), .iss_addr(iss_addr_e), .iss_uid(iss_uid_e),
    .res_v(res_v_e), .res_stg(res_stg_e), .res_data(res_data_e),
    .st_vld(vld_e), .st_wr(wr_e), .st_rdy(rdy_e), .st_addr(addr_e), .st_data(data_e));

  spu_fwd_pipe #(.QUADWORD(QW), .REG_ADDR_WIDTH(AW), .UNIT_ID_SIZE(UNIT_ID_SIZE),
                 .DEPTH(DEPTH), .STG_W(STG_W)) u_pipe_o (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_v(iss_v_o), .iss_wr(iss_wr_o), .iss_addr(iss_addr_o), .iss_uid(iss_uid_o),
    .res_v(res_v_o), .res_stg(res_stg_o), .res_data(res_data_o),
    .st_vld(vld_o), .st_wr(wr_o), .st_rdy(rdy_o), .st_addr(addr_o), .st_data(data_o));

  // Writeback is driven straight off the stage-DEPTH registers.
  logic unrdy_e, unrdy_o, err_q;
  assign wb_en_e   = vld_e[DEPTH] & wr_e[DEPTH] & rdy_e[DEPTH];
  assign wb_en_o   = vld_o[DEPTH] & wr_o[DEPTH] & rdy_o[DEPTH];
  assign wb_addr_e = addr_e[DEPTH];
  assign wb_addr_o = addr_o[DEPTH];
  assign wb_data_e = data_e[DEPTH];
  assign wb_data_o = data_o[DEPTH];
  assign unrdy_e   = vld_e[DEPTH] & wr_e[DEPTH] & ~rdy_e[DEPTH];
  assign unrdy_o   = vld_o[DEPTH] & wr_o[DEPTH] & ~rdy_o[DEPTH];

  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | unrdy_e | unrdy_o;

  assign err_unready = err_q | unrdy_e | unrdy_o;

  logic [NUM_RD-1:0][AW-1:0] rd_arr;
  logic [NUM_RD-1:0][QW-1:0] rf_arr, op_arr;
  logic [NUM_RD-1:0]         hz;

  // Flattened buses carry port 0 in the most significant slice.
  always_comb begin
    rd_arr  = '0;
    rf_arr  = '0;
    op_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_arr[i] = rd_addr[(NUM_RD-1-i)*AW +: AW];
      rf_arr[i] = rf_data[(NUM_RD-1-i)*QW +: QW];
      op_data[(NUM_RD-1-i)*QW +: QW] = op_arr[i];
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    spu_fwd_port #(.QUADWORD(QW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)) u_port (
      .rd_addr(rd_arr[i]), .rf_data(rf_arr[i]),
      .vld_e(vld_e), .wr_e(wr_e), .rdy_e(rdy_e), .addr_e(addr_e), .data_e(data_e),
      .vld_o(vld_o), .wr_o(wr_o), .rdy_o(rdy_o), .addr_o(addr_o), .data_o(data_o),
      .op_data(op_arr[i]), .op_hazard(hz[i]));
  end

  assign op_hazard = hz;

  always_ff @(posedge clk or posedge reset)
    if (reset)                                  hazard_cnt <= '0;
    else if (|hz && hazard_cnt != 16'hFFFF)     hazard_cnt <= hazard_cnt + 16'd1;
endmodule

// File: doc/spu_fwd_network.md
Name: spu_fwd_network

Overview:
- Parametrised result-forwarding network for the dual-issue SPU; generalises the fixed even/odd forward macro.
- Holds a DEPTH-stage result shift register per pipe (even, odd). Execution units deposit results at a run-time-selected stage.
- Drains stage DEPTH to the register file write ports.
- Supplies bypassed operands plus per-port hazard flags to NUM_RD read ports.

Parameters:
QUADWORD, 128, operand/result data width
REG_ADDR_WIDTH, 7, register address width
UNIT_ID_SIZE, 3, execution-unit id width
DEPTH, 8, stages per pipe (>=2); stage DEPTH is writeback
NUM_RD, 5, operand read ports (even ra/rb/rc, odd ra/rb)
STG_W, 4, width of stage index, >= clog2(DEPTH+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous invalidate of all in-flight entries
iss_v_e / iss_v_o  in  1  issue valid, even / odd
iss_wr_e / iss_wr_o  in  1  instruction writes rt
iss_addr_e / iss_addr_o  in  REG_ADDR_WIDTH  rt address
iss_uid_e / iss_uid_o  in  UNIT_ID_SIZE  producing unit id
res_v_e / res_v_o  in  1  result delivery valid
res_stg_e / res_stg_o  in  STG_W  stage (1..DEPTH) receiving the result
res_data_e / res_data_o  in  QUADWORD  result data
wb_en_e / wb_en_o  out  1  register-file write enable
wb_addr_e / wb_addr_o  out  REG_ADDR_WIDTH  write address
wb_data_e / wb_data_o  out  QUADWORD  write data
rd_addr  in  NUM_RD*REG_ADDR_WIDTH  flattened read addresses, port 0 at MSBs
rf_data  in  NUM_RD*QUADWORD  register-file read data, same packing
op_data  out  NUM_RD*QUADWORD  bypassed operands
op_hazard  out  NUM_RD  operand not yet available
err_unready  out  1  sticky: entry reached writeback without result
hazard_cnt  out  16  saturating count of cycles with any op_hazard set

Behaviour:
- Entry fields: valid, wr, addr, uid, ready, data. Stages are registers 1..DEPTH per pipe.
- Each clk, every stage k takes the contents of stage k-1.
  - Stage 1 loads {iss_v, iss_wr, iss_addr, iss_uid, ready=0, data=0}.
  - Stage DEPTH contents leave the network.
- Result write:
  - If res_v and res_stg=k (1..DEPTH), the next-state entry for stage k gets ready=1 and data=res_data. This is the entry shifting in from k-1, or the issue entry when k=1.
  - Write applies only if that entry is valid and wr=1; otherwise the write is ignored.
  - res_stg of 0 or >DEPTH is ignored.
- Writeback outputs are registered from stage DEPTH:
  - wb_en = valid & wr & ready; wb_addr/wb_data = entry fields.
  - If valid & wr & !ready, set err_unready (held until reset) and keep wb_en=0.
- Bypass (combinational, per port i):
  - Candidates: all valid & wr entries in stages 1..DEPTH of both pipes with addr==rd_addr[i]. Stage DEPTH is included, because RF write-then-read in the same cycle is not guaranteed.
  - Youngest candidate wins (lowest stage number). On a same-stage tie, odd wins (odd issues later in program order).
  - Winner ready: op_data[i]=winner.data, op_hazard[i]=0.
  - Winner not ready: op_data[i]=rf_data[i], op_hazard[i]=1.
  - No candidate: op_data[i]=rf_data[i], op_hazard[i]=0.
- hazard_cnt increments by 1 in each cycle where |op_hazard; it saturates at 16'hFFFF.
- flush:
  - Next-state valid=0 in all stages of both pipes; the same-cycle issue is dropped and res writes are ignored.
  - wb_en is 0 in the following cycle.
  - err_unready and hazard_cnt are unaffected.
- reset (async, any time, including mid-flight):
  - All valid/ready = 0.
  - wb_en_*=0, wb_addr_*=0, wb_data_*=0, err_unready=0, hazard_cnt=0.
  - op_hazard=0 and op_data=rf_data immediately, since no entries remain.
- Latency: an instruction issued in cycle t appears on wb_* in cycle t+DEPTH.

Test Plan:
- Reset, then iss_v_e=1, addr=5, wr=1, res_stg_e=2 with data=0xA5..A5 one cycle later -> wb_en_e=1, addr 5, data 0xA5..A5 exactly DEPTH cycles after issue; no other wb pulses.
- Issue even addr=9. Read port 0 addr=9 at stage 1 -> op_hazard[0]=1, op_data=rf_data. After res at stage 3 -> hazard 0, op_data=result; hazard_cnt advanced by 2.
- Even and odd both write addr=12 at the same stage, both ready -> every port reading 12 returns the odd data. An older even entry at a higher stage is overridden by a younger odd entry.
- Entry with no result reaches stage DEPTH -> wb_en=0, err_unready=1 and stays 1; res_stg=0 or DEPTH+1 changes nothing.
- flush with 4 entries in flight plus a same-cycle issue -> no wb_en for the next DEPTH cycles, op_hazard all 0; hazard_cnt is preserved.
- Assert reset mid-flight between clock edges -> outputs clear immediately; the pipeline resumes cleanly after release. Force 65536+ hazard cycles -> hazard_cnt holds 0xFFFF.
